// File: rtl/serial_subtractor.sv
// serial_subtractor
//   Bit-serial two's-complement subtractor. On start the parallel operands are
//   latched. They are then streamed LSB first through a one-bit full subtractor
//   with a registered borrow. After WIDTH shift cycles the module presents
//   (A - B) mod 2^WIDTH together with an unsigned underflow flag.
//
// Ports
//   clock_sub_i   in   1      clock; all state updates on posedge
//   resetn_sub_i  in   1      asynchronous active-low reset
//   start_sub_i   in   1      request; only honoured while idle
//   a_sub_i       in   WIDTH  minuend, sampled with start
//   b_sub_i       in   WIDTH  subtrahend, sampled with start
//   diff_o        out  WIDTH  registered result, held between completions
//   borrow_o      out  1      registered underflow flag (A < B unsigned)
//   busy_o        out  1      high while shifting
//   done_o        out  1      one-cycle pulse when diff_o/borrow_o update
module serial_subtractor #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clock_sub_i,
    input  logic             resetn_sub_i,
    input  logic             start_sub_i,
    input  logic [WIDTH-1:0] a_sub_i,
    input  logic [WIDTH-1:0] b_sub_i,
    output logic [WIDTH-1:0] diff_o,
    output logic             borrow_o,
    output logic             busy_o,
    output logic             done_o
);

    localparam int unsigned CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_a_sr;
    logic [WIDTH-1:0] r_b_sr;
    logic [WIDTH-1:0] r_res_sr;
    logic             r_borrow;
    logic [CW-1:0]    r_count;

    logic             w_a0;
    logic             w_b0;
    logic             w_d;
    logic             w_borrow_next;
    logic [WIDTH-1:0] w_res_next;

    // One-bit full subtractor on the current LSBs.
    always_comb begin
        w_a0          = r_a_sr[0];
        w_b0          = r_b_sr[0];
        w_d           = w_a0 ^ w_b0 ^ r_borrow;
        w_borrow_next = (~w_a0 & w_b0) | (~(w_a0 ^ w_b0) & r_borrow);
        w_res_next    = {w_d, r_res_sr[WIDTH-1:1]};
    end

    always_ff @(posedge clock_sub_i or negedge resetn_sub_i) begin
        if (!resetn_sub_i) begin
            r_state  <= IDLE;
            r_a_sr   <= '0;
            r_b_sr   <= '0;
            r_res_sr <= '0;
            r_borrow <= 1'b0;
            r_count  <= '0;
            diff_o   <= '0;
            borrow_o <= 1'b0;
            busy_o   <= 1'b0;
            done_o   <= 1'b0;
        end else begin
            done_o <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (start_sub_i) begin
                        r_a_sr   <= a_sub_i;
                        r_b_sr   <= b_sub_i;
                        r_borrow <= 1'b0;
                        r_count  <= '0;
                        busy_o   <= 1'b1;
                        r_state  <= SHIFT;
                    end
                end
                SHIFT: begin
                    r_a_sr   <= r_a_sr >> 1;
                    r_b_sr   <= r_b_sr >> 1;
                    r_res_sr <= w_res_next;
                    r_borrow <= w_borrow_next;
                    if (r_count == LAST) begin
                        // Final bit: publish the assembled word and the
                        // borrow out of the MSB stage in the same edge.
                        diff_o   <= w_res_next;
                        borrow_o <= w_borrow_next;
                        done_o   <= 1'b1;
                        busy_o   <= 1'b0;
                        r_state  <= IDLE;
                    end else begin
                        r_count <= r_count + CW'(1);
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_serial_subtractor.sv
module tb_serial_subtractor;

    typedef struct {
        logic [7:0] diff;
        logic       borrow;
    } exp_t;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] diff;
        logic       borrow;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    logic        start8 = 1'b0;
    logic [7:0]  a8 = '0, b8 = '0, diff8;
    logic        borrow8, busy8, done8;

    logic        start2 = 1'b0;
    logic [1:0]  a2 = '0, b2 = '0, diff2;
    logic        borrow2, busy2, done2;

    logic        start16 = 1'b0;
    logic [15:0] a16 = '0, b16 = '0, diff16;
    logic        borrow16, busy16, done16;

    int   n_checks = 0;
    int   n_fail   = 0;
    int   n_done   = 0;
    exp_t sb_q[$];

    always #5 clk = ~clk;

    serial_subtractor #(.WIDTH(8)) u_dut8 (
        .clock_sub_i (clk),     .resetn_sub_i (rst_n),  .start_sub_i (start8),
        .a_sub_i     (a8),      .b_sub_i      (b8),     .diff_o      (diff8),
        .borrow_o    (borrow8), .busy_o       (busy8),  .done_o      (done8)
    );

    serial_subtractor #(.WIDTH(2)) u_dut2 (
        .clock_sub_i (clk),     .resetn_sub_i (rst_n),  .start_sub_i (start2),
        .a_sub_i     (a2),      .b_sub_i      (b2),     .diff_o      (diff2),
        .borrow_o    (borrow2), .busy_o       (busy2),  .done_o      (done2)
    );

    serial_subtractor #(.WIDTH(16)) u_dut16 (
        .clock_sub_i (clk),      .resetn_sub_i (rst_n),  .start_sub_i (start16),
        .a_sub_i     (a16),      .b_sub_i      (b16),    .diff_o      (diff16),
        .borrow_o    (borrow16), .busy_o       (busy16), .done_o      (done16)
    );

    task automatic chk(input string nm, input longint unsigned act, input longint unsigned exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    task automatic push_exp(input logic [7:0] a, input logic [7:0] b);
        exp_t e;
        e.diff   = a - b;
        e.borrow = (a < b);
        sb_q.push_back(e);
    endtask

    // Scoreboard consumer for the 8-bit instance.
    always @(negedge clk) begin
        if (rst_n && done8) begin
            n_done++;
            if (sb_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL sb_unexpected_done: got diff %0h with no pending result", diff8);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                chk("sb_diff", diff8, e.diff);
                chk("sb_borrow", borrow8, e.borrow);
            end
        end
    end

    // One 8-bit operation; returns start-to-done latency and busy cycle count.
    task automatic run8(input logic [7:0] a, input logic [7:0] b, output int lat, output int bc);
        @(negedge clk);
        a8 = a; b8 = b; start8 = 1'b1;
        push_exp(a, b);
        @(negedge clk);
        start8 = 1'b0;
        a8 = 8'($urandom); b8 = 8'($urandom);
        lat = 0;
        bc  = int'(busy8);
        while (!done8 && lat < 40) begin
            @(negedge clk);
            lat++;
            bc += int'(busy8);
        end
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got no end of test, expected completion");
        $fatal(1);
    end

    initial begin
        vec_t vecs[8];
        int lat, bc, nd0, cyc, prev, nd, idx, guard;
        logic [7:0]  ra, rb;
        logic [15:0] ea16, eb16, ed16;
        logic [1:0]  ea2, eb2, ed2;

        vecs[0] = '{a: 8'd200, b: 8'd55,  diff: 8'd145,  borrow: 1'b0};
        vecs[1] = '{a: 8'd55,  b: 8'd200, diff: 8'h6F,   borrow: 1'b1};
        vecs[2] = '{a: 8'd0,   b: 8'd1,   diff: 8'd255,  borrow: 1'b1};
        vecs[3] = '{a: 8'd255, b: 8'd255, diff: 8'd0,    borrow: 1'b0};
        vecs[4] = '{a: 8'd128, b: 8'd127, diff: 8'd1,    borrow: 1'b0};
        vecs[5] = '{a: 8'd127, b: 8'd128, diff: 8'd255,  borrow: 1'b1};
        vecs[6] = '{a: 8'd0,   b: 8'd0,   diff: 8'd0,    borrow: 1'b0};
        vecs[7] = '{a: 8'd1,   b: 8'd0,   diff: 8'd1,    borrow: 1'b0};

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_diff", diff8, 0);
        chk("rst_borrow", borrow8, 0);
        chk("rst_busy", busy8, 0);
        chk("rst_done", done8, 0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Directed table: values, latency and busy length
        for (int i = 0; i < 8; i++) begin
            run8(vecs[i].a, vecs[i].b, lat, bc);
            chk("tbl_latency", lat, 8);
            chk("tbl_busy_cycles", bc, 8);
            chk("tbl_diff", diff8, vecs[i].diff);
            chk("tbl_borrow", borrow8, vecs[i].borrow);
        end

        // Start pulse mid-shift must be ignored
        @(negedge clk);
        a8 = 8'h10; b8 = 8'h01; start8 = 1'b1;
        push_exp(8'h10, 8'h01);
        @(negedge clk);
        start8 = 1'b0;
        nd0 = n_done;
        repeat (2) @(negedge clk);
        a8 = 8'hFF; b8 = 8'h00; start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        repeat (14) @(negedge clk);
        chk("midstart_done_count", n_done - nd0, 1);
        chk("midstart_diff_held", diff8, 8'h0F);

        // Reset during an operation aborts it
        @(negedge clk);
        a8 = 8'h50; b8 = 8'h20; start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("abort_diff", diff8, 0);
        chk("abort_borrow", borrow8, 0);
        chk("abort_busy", busy8, 0);
        chk("abort_done", done8, 0);
        @(negedge clk);
        rst_n = 1'b1;
        nd0 = n_done;
        repeat (12) @(negedge clk);
        chk("abort_no_done", n_done - nd0, 0);
        run8(8'd9, 8'd3, lat, bc);
        chk("post_abort_diff", diff8, 6);
        chk("post_abort_latency", lat, 8);

        // Back-to-back: start held high, new operands offered in each done cycle
        @(negedge clk);
        ra = 8'($urandom); rb = 8'($urandom);
        a8 = ra; b8 = rb; start8 = 1'b1;
        push_exp(ra, rb);
        idx = 1; nd = 0; cyc = 0; prev = -1; guard = 0;
        while (nd < 20 && guard < 400) begin
            @(negedge clk);
            guard++;
            cyc++;
            if (done8) begin
                nd++;
                if (prev >= 0) chk("b2b_interval", cyc - prev, 9);
                prev = cyc;
                if (idx < 20) begin
                    ra = 8'($urandom); rb = 8'($urandom);
                    a8 = ra; b8 = rb;
                    push_exp(ra, rb);
                    idx++;
                end else begin
                    start8 = 1'b0;
                end
            end else begin
                a8 = 8'($urandom); b8 = 8'($urandom);
            end
        end
        start8 = 1'b0;
        chk("b2b_count", nd, 20);

        // Random scoreboard run
        for (int i = 0; i < 1000; i++) begin
            run8(8'($urandom), 8'($urandom), lat, bc);
            if (lat != 8) chk("rnd_latency", lat, 8);
        end

        // WIDTH = 2, exhaustive
        for (int i = 0; i < 16; i++) begin
            ea2 = 2'(i); eb2 = 2'(i >> 2); ed2 = ea2 - eb2;
            @(negedge clk);
            a2 = ea2; b2 = eb2; start2 = 1'b1;
            @(negedge clk);
            start2 = 1'b0; a2 = 2'($urandom); b2 = 2'($urandom);
            lat = 0;
            while (!done2 && lat < 40) begin
                @(negedge clk);
                lat++;
            end
            chk("w2_latency", lat, 2);
            chk("w2_diff", diff2, ed2);
            chk("w2_borrow", borrow2, ea2 < eb2);
        end

        // WIDTH = 16, random
        for (int i = 0; i < 200; i++) begin
            ea16 = 16'($urandom); eb16 = 16'($urandom); ed16 = ea16 - eb16;
            @(negedge clk);
            a16 = ea16; b16 = eb16; start16 = 1'b1;
            @(negedge clk);
            start16 = 1'b0; a16 = 16'($urandom); b16 = 16'($urandom);
            lat = 0;
            while (!done16 && lat < 40) begin
                @(negedge clk);
                lat++;
            end
            chk("w16_latency", lat, 16);
            chk("w16_diff", diff16, ed16);
            chk("w16_borrow", borrow16, ea16 < eb16);
        end

        repeat (3) @(negedge clk);
        chk("sb_empty", sb_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
